rr_mux_arbiter_4: RTL and testbench
===================================

# rr_mux_arbiter_4

Four-requester round-robin arbiter that shares a single 4:1 data mux and a one-entry registered output slot among four valid/ready producers. Each cycle it picks one requester fairly, drives the mux select, and captures the selected word and its source index into the output register. It sits in front of a single downstream consumer that needs one merged, tagged stream from four sources.

## Interface
- WIDTH, 4, data width of each requester word and of the output word

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  4  bit i: requester i presents a word
- req_data0, req_data1, req_data2, req_data3  input  WIDTH each  requester words
- req_ready  output  4  bit i: word from requester i accepted this cycle (one-hot or zero)
- out_valid  output  1  output slot holds a word
- out_data  output  WIDTH  captured word
- out_src  output  2  index of requester that supplied out_data
- out_ready  input  1  consumer accepts output slot this cycle

## Operation
- Registered state: out_valid, out_data, out_src, ptr (2-bit index of last granted requester).
- Two-state slot FSM: EMPTY (out_valid=0), FULL (out_valid=1).
- slot_free = !out_valid || out_ready.
- Arbitration (combinational): search order ptr+1, ptr+2, ptr+3, ptr (mod 4); winner = first index with req_valid set; none if req_valid=0.
- req_ready[winner]=1 only when slot_free and a winner exists; all other bits 0. req_ready may depend on req_valid; req_valid must not depend on req_ready.
- Mux: sel = winner; out word = req_data{sel}.
- Transfer (slot_free and winner exists): out_data <= req_data{winner}, out_src <= winner, out_valid <= 1, ptr <= winner.
- slot_free and no winner: out_valid <= 0; out_data, out_src, ptr hold.
- !slot_free (FULL, out_ready=0): all registers hold; req_ready=0.
- Simultaneous out_ready and new winner: old word leaves, new word loaded same edge; out_valid stays 1.
- Fairness: a requester holding req_valid continuously is granted within 4 transfers.
- ptr advances only on a transfer, never on idle cycles.
- Requesters must hold req_valid and data stable until their req_ready.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_src=0, ptr=3 (requester 0 first priority); req_ready forced to 0 while rst_n low.
- First grant possible on first rising edge after rst_n deasserts.
- Latency: accept at edge N -> out_valid/out_data/out_src visible after edge N.
- Throughput: one word per cycle with out_ready held 1.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_src do not change.
- Reset mid-operation: slot contents discarded, out_valid drops immediately, ptr returns to 3.

## Test plan
- Reset: rst_n=0 with req_valid=4'b1111 -> req_ready=0, out_valid=0, out_data=0, out_src=0; after release with out_ready=1, first accept is requester 0.
- Full contention: req_valid=4'b1111, data0..3=4'hA,4'hB,4'hC,4'hD, out_ready=1 -> out_src sequence 0,1,2,3,0, out_data A,B,C,D,A, one per cycle.
- Backpressure: slot FULL with out_src=1, out_data=4'hB, out_ready=0 for 3 cycles -> req_ready=0, out_data/out_src held; out_ready=1 -> next grant 2.
- Sparse requests: ptr=1, req_valid=4'b0001 -> requester 0 granted, ptr=0; then req_valid=4'b1001 -> requester 3 before 0.
- Drain: single word accepted, req_valid=0, out_ready=1 -> out_valid drops next cycle; ptr unchanged.
- Async reset mid-stream: rst_n pulsed low between edges while out_valid=1 -> out_valid=0 immediately, next grant order restarts at 0.

Source files
------------

// File: rtl/rr_mux_arbiter_4.sv
// Four-requester round-robin arbiter feeding a shared 4:1 data mux into a
// one-entry registered output slot tagged with the source index.
module rr_mux_arbiter_4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [WIDTH-1:0] req_data2,
  input  logic [WIDTH-1:0] req_data3,
  output logic [3:0]       req_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t      state;
  slot_state_t      state_next;
  logic [1:0]       ptr;
  logic [1:0]       cand;
  logic [1:0]       winner;
  logic             found;
  logic             slot_free;
  logic             transfer;
  logic [WIDTH-1:0] sel_data;

  // Search starts just after the last grant and ends on it, so ptr itself
  // has lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = ptr;
    cand   = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    case (winner)
      2'd0:    sel_data = req_data0;
      2'd1:    sel_data = req_data1;
      2'd2:    sel_data = req_data2;
      default: sel_data = req_data3;
    endcase
  end

  always_comb begin
    out_valid = (state == FULL);
    slot_free = !out_valid || out_ready;
    transfer  = slot_free && found;
    req_ready = (transfer && rst_n) ? (4'b0001 << winner) : '0;
  end

  always_comb begin
    state_next = state;
    if (slot_free) begin
      state_next = found ? FULL : EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      out_data <= '0;
      out_src  <= '0;
      ptr      <= 2'd3;
    end else begin
      state <= state_next;
      if (transfer) begin
        out_data <= sel_data;
        out_src  <= winner;
        ptr      <= winner;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Self-checking bench for rr_mux_arbiter_4: directed scenarios plus a
// randomized run against a behavioural round-robin model.
module tb_rr_mux_arbiter_4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [3:0] d [4];
  logic [3:0] req_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_src;
  logic       out_ready;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit         m_valid;
  logic [3:0] m_data;
  logic [1:0] m_src;
  int         m_ptr;

  always #5 clk = ~clk;

  rr_mux_arbiter_4 #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data0 (d[0]),
    .req_data1 (d[1]),
    .req_data2 (d[2]),
    .req_data3 (d[3]),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  function automatic int model_winner();
    for (int k = 1; k <= 4; k++) begin
      if (req_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int w;
    w = model_winner();
    if (rst_n && (!m_valid || out_ready) && w >= 0) return 4'(1 << w);
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_data  = 4'h0;
    m_src   = 2'd0;
    m_ptr   = 3;
  endtask

  // Advance the model over one clock edge, then move to just after it.
  task automatic step();
    int w;
    w = model_winner();
    if (!m_valid || out_ready) begin
      if (w >= 0) begin
        m_valid = 1;
        m_data  = d[w];
        m_src   = 2'(w);
        m_ptr   = w;
      end else begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] e);
    d[0] = a; d[1] = b; d[2] = c; d[3] = e;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    out_ready = 1'b0;
    #3;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    set_data(4'hA, 4'hB, 4'hC, 4'hD);
    model_reset();
    #1;
    tests++;
    if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    tests++;
    if (out_data !== 4'h0) begin fails++; $display("FAIL reset_data got=%h exp=0", out_data); end
    tests++;
    if (out_src !== 2'd0) begin fails++; $display("FAIL reset_src got=%0d exp=0", out_src); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL reset_first_ready got=%b exp=0001", req_ready); end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 4'hA) begin
      fails++;
      $display("FAIL reset_first_grant got v=%b src=%0d data=%h exp v=1 src=0 data=a", out_valid, out_src, out_data);
    end
  endtask

  task automatic test_contention();
    logic [3:0] exp_d [4];
    apply_reset();
    set_data(4'hA, 4'hB, 4'hC, 4'hD);
    exp_d[0] = 4'hA; exp_d[1] = 4'hB; exp_d[2] = 4'hC; exp_d[3] = 4'hD;
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (req_ready !== 4'(1 << (i % 4))) begin
        fails++; $display("FAIL contention_ready[%0d] got=%b exp=%b", i, req_ready, 4'(1 << (i % 4)));
      end
      step();
      tests++;
      if (out_valid !== 1'b1 || out_src !== 2'(i % 4) || out_data !== exp_d[i % 4]) begin
        fails++;
        $display("FAIL contention_out[%0d] got v=%b src=%0d data=%h exp v=1 src=%0d data=%h",
                 i, out_valid, out_src, out_data, i % 4, exp_d[i % 4]);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_data(4'hA, 4'hB, 4'hC, 4'hD);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, req_ready); end
      step();
      tests++;
      if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 4'hB) begin
        fails++;
        $display("FAIL bp_hold[%0d] got v=%b src=%0d data=%h exp v=1 src=1 data=b", i, out_valid, out_src, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin fails++; $display("FAIL bp_release_ready got=%b exp=0100", req_ready); end
    step();
    tests++;
    if (out_src !== 2'd2 || out_data !== 4'hC) begin
      fails++; $display("FAIL bp_release_out got src=%0d data=%h exp src=2 data=c", out_src, out_data);
    end
  endtask

  task automatic test_sparse();
    apply_reset();
    set_data(4'h1, 4'h2, 4'h3, 4'h4);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    step();
    step();
    req_valid = 4'b0001;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL sparse_wrap_ready got=%b exp=0001", req_ready); end
    step();
    tests++;
    if (out_src !== 2'd0 || out_data !== 4'h1) begin
      fails++; $display("FAIL sparse_wrap_out got src=%0d data=%h exp src=0 data=1", out_src, out_data);
    end
    req_valid = 4'b1001;
    #1;
    tests++;
    if (req_ready !== 4'b1000) begin fails++; $display("FAIL sparse_order_ready got=%b exp=1000", req_ready); end
    step();
    tests++;
    if (out_src !== 2'd3 || out_data !== 4'h4) begin
      fails++; $display("FAIL sparse_order_out got src=%0d data=%h exp src=3 data=4", out_src, out_data);
    end
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL sparse_next_ready got=%b exp=0001", req_ready); end
    step();
  endtask

  task automatic test_drain();
    apply_reset();
    set_data(4'h5, 4'h6, 4'h7, 4'h8);
    req_valid = 4'b0100;
    out_ready = 1'b1;
    step();
    req_valid = 4'b0000;
    step();
    tests++;
    if (out_valid !== 1'b0 || out_src !== 2'd2 || out_data !== 4'h7) begin
      fails++;
      $display("FAIL drain_out got v=%b src=%0d data=%h exp v=0 src=2 data=7", out_valid, out_src, out_data);
    end
    step();
    req_valid = 4'b1111;
    #1;
    tests++;
    if (req_ready !== 4'b1000) begin fails++; $display("FAIL drain_ptr_ready got=%b exp=1000", req_ready); end
    step();
  endtask

  task automatic test_async_reset();
    apply_reset();
    set_data(4'h9, 4'hE, 4'hF, 4'h3);
    req_valid = 4'b1111;
    out_ready = 1'b1;
    step();
    step();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if (out_valid !== 1'b0 || out_src !== 2'd0 || out_data !== 4'h0) begin
      fails++;
      $display("FAIL async_rst_out got v=%b src=%0d data=%h exp v=0 src=0 data=0", out_valid, out_src, out_data);
    end
    tests++;
    if (req_ready !== 4'b0000) begin fails++; $display("FAIL async_rst_ready got=%b exp=0000", req_ready); end
    #1;
    rst_n = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin fails++; $display("FAIL async_restart_ready got=%b exp=0001", req_ready); end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_src !== 2'd0 || out_data !== 4'h9) begin
      fails++;
      $display("FAIL async_restart_out got v=%b src=%0d data=%h exp v=1 src=0 data=9", out_valid, out_src, out_data);
    end
  endtask

  task automatic test_random();
    logic [3:0] g;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          d[i] = 4'($urandom_range(0, 15));
        end
      end
      #1;
      g = model_ready();
      tests++;
      if (req_ready !== g) begin fails++; $display("FAIL rand_ready[%0d] got=%b exp=%b", n, req_ready, g); end
      step();
      tests++;
      if (out_valid !== m_valid || out_src !== m_src || out_data !== m_data) begin
        fails++;
        $display("FAIL rand_out[%0d] got v=%b src=%0d data=%h exp v=%b src=%0d data=%h",
                 n, out_valid, out_src, out_data, m_valid, m_src, m_data);
      end
      for (int i = 0; i < 4; i++) begin
        if (g[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          d[i] = 4'($urandom_range(0, 15));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_backpressure();
    test_sparse();
    test_drain();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
